// File: rtl/oled_frame_streamer.sv
// Page-organised monochrome framebuffer with pixel writes, a clear engine and a
// valid/ready byte streamer that emits the SSD1306-style address header and then the frame.
module oled_frame_streamer #(
  parameter int DISPLAY_WIDTH  = 128,
  parameter int DISPLAY_HEIGHT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_we,
  input  logic [6:0] pix_x,
  input  logic [5:0] pix_y,
  input  logic       pix_val,
  input  logic       clear,
  input  logic       frame_start,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned PAGES  = DISPLAY_HEIGHT / 8;
  localparam int unsigned NBYTES = DISPLAY_WIDTH * PAGES;
  localparam int unsigned AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HEADER,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      hdr_q, hdr_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            dc_q, dc_d;

  logic [7:0]      fb [NBYTES];
  logic [AW-1:0]   pix_addr;
  logic            pix_in_range;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      rd_byte;
  logic            xfer;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h21;
      3'd2:    return 8'(DISPLAY_WIDTH - 1);
      3'd3:    return 8'h22;
      3'd5:    return 8'(PAGES - 1);
      default: return 8'h00;
    endcase
  endfunction

  assign pix_in_range = (32'(pix_x) < 32'(DISPLAY_WIDTH)) && (32'(pix_y) < 32'(DISPLAY_HEIGHT));
  assign pix_addr     = AW'((32'(pix_y) >> 3) * 32'(DISPLAY_WIDTH) + 32'(pix_x));
  assign xfer         = valid_q && byte_ready;

  // The next byte is fetched at the moment the current one is accepted, so the
  // output register simply holds through any stall.
  always_comb begin
    rd_addr = (state_q == S_HEADER) ? '0 : addr_q + 1'b1;
    rd_byte = fb[rd_addr];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hdr_d   = hdr_q;
    valid_d = valid_q;
    data_d  = data_q;
    dc_d    = dc_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          addr_d  = '0;
        end else if (frame_start) begin
          state_d = S_HEADER;
          hdr_d   = '0;
          valid_d = 1'b1;
          data_d  = hdr_byte(3'd0);
          dc_d    = 1'b0;
        end
      end
      S_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          if (hdr_q == 3'd5) begin
            state_d = S_STREAM;
            addr_d  = '0;
            data_d  = rd_byte;
            dc_d    = 1'b1;
          end else begin
            hdr_d  = hdr_q + 3'd1;
            data_d = hdr_byte(hdr_q + 3'd1);
          end
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            addr_d  = '0;
            valid_d = 1'b0;
            data_d  = '0;
            dc_d    = 1'b0;
          end else begin
            addr_d = addr_q + 1'b1;
            data_d = rd_byte;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hdr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hdr_q   <= hdr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
    end
  end

  // Framebuffer is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      fb[addr_q] <= '0;
    end else if (pix_we && pix_in_range) begin
      fb[pix_addr][pix_y[2:0]] <= pix_val;
    end
  end

  assign byte_data  = data_q;
  assign byte_dc    = dc_q;
  assign byte_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench for oled_frame_streamer: header/data ordering, pixel mapping,
// stalls, ignored requests and mid-frame reset.
module tb_oled_frame_streamer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_we;
  logic [6:0] pix_x;
  logic [5:0] pix_y;
  logic       pix_val;
  logic       clear;
  logic       frame_start;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       frame_done;

  oled_frame_streamer #(.DISPLAY_WIDTH(128), .DISPLAY_HEIGHT(64)) dut (
    .clk(clk), .reset(reset), .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y),
    .pix_val(pix_val), .clear(clear), .frame_start(frame_start),
    .byte_data(byte_data), .byte_dc(byte_dc), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] x;
    logic [5:0] y;
    logic       v;
    int         addr;
    logic [7:0] exp;
  } pvec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0] fb_m [1024];
  logic [7:0] cap_data [2048];
  logic       cap_dc [2048];
  int         cap_n;
  int         done_cnt;
  logic [7:0] hdr_exp [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_pix(input logic [6:0] x, input logic [5:0] y, input logic v);
    int a;
    pix_we = 1'b1; pix_x = x; pix_y = y; pix_val = v;
    @(negedge clk);
    pix_we = 1'b0;
    a = (int'(y) / 8) * 128 + int'(x);
    fb_m[a][y % 8] = v;
  endtask

  task automatic clear_wait(output int n, output int vseen);
    n = 0; vseen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      clear = 1'b0; frame_start = 1'b0;
      if (!busy) break;
      n++;
      if (byte_valid) vseen++;
    end
    for (int i = 0; i < 1024; i++) fb_m[i] = 8'h00;
  endtask

  // Drives one frame request and captures every accepted byte.
  task automatic run_frame(input bit rnd, input int abort_at, input bit poke);
    bit         stalled = 1'b0;
    bit         finished = 1'b0;
    bit         r;
    logic [7:0] pd = '0;
    logic       pdc = 1'b0;
    cap_n = 0; done_cnt = 0;
    frame_start = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      frame_start = 1'b0; clear = 1'b0;
      if (stalled) begin
        chk("stall_valid", 32'(byte_valid), 32'd1);
        chk("stall_data", 32'(byte_data), 32'(pd));
        chk("stall_dc", 32'(byte_dc), 32'(pdc));
      end
      if (!byte_valid && byte_data !== 8'h00) chk("idle_data_zero", 32'(byte_data), 32'd0);
      if (frame_done) begin done_cnt++; finished = 1'b1; break; end
      if (abort_at > 0 && cap_n == 6 + abort_at) begin finished = 1'b1; break; end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_ready = r;
      if (byte_valid && r) begin
        cap_data[cap_n] = byte_data; cap_dc[cap_n] = byte_dc; cap_n++;
      end
      stalled = byte_valid && !r; pd = byte_data; pdc = byte_dc;
      if (poke && cap_n == 100) frame_start = 1'b1;
      if (poke && cap_n == 200) clear = 1'b1;
    end
    if (!finished) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int bad = 0;
    chk({tag, "_count"}, 32'(cap_n), 32'd1030);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_hdr_byte"}, 32'(cap_data[i]), 32'(hdr_exp[i]));
      chk({tag, "_hdr_dc"}, 32'(cap_dc[i]), 32'd0);
    end
    for (int i = 0; i < 1024; i++) begin
      if (cap_data[6+i] !== fb_m[i] || cap_dc[6+i] !== 1'b1) begin
        bad++;
        if (bad < 4) $display("FAIL %s_data addr %0d got %0h/%0b expected %0h/1",
                              tag, i, cap_data[6+i], cap_dc[6+i], fb_m[i]);
      end
    end
    checks++;
    if (bad != 0) errors++;
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_after"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    pvec_t pv [8];
    int n, vs, vlate;

    hdr_exp[0] = 8'h21; hdr_exp[1] = 8'h00; hdr_exp[2] = 8'h7F;
    hdr_exp[3] = 8'h22; hdr_exp[4] = 8'h00; hdr_exp[5] = 8'h07;
    // exp is the byte value after the whole table has been written
    pv[0] = '{7'd0,   6'd0,  1'b1, 0,    8'h01};
    pv[1] = '{7'd5,   6'd9,  1'b1, 133,  8'h02};
    pv[2] = '{7'd127, 6'd63, 1'b1, 1023, 8'h80};
    pv[3] = '{7'd10,  6'd16, 1'b1, 266,  8'h02};
    pv[4] = '{7'd10,  6'd17, 1'b1, 266,  8'h02};
    pv[5] = '{7'd10,  6'd16, 1'b0, 266,  8'h02};
    pv[6] = '{7'd64,  6'd31, 1'b1, 448,  8'h81};
    pv[7] = '{7'd64,  6'd24, 1'b1, 448,  8'h81};

    reset = 1'b1; pix_we = 1'b0; pix_x = '0; pix_y = '0; pix_val = 1'b0;
    clear = 1'b0; frame_start = 1'b0; byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_data", 32'(byte_data), 32'd0);
    chk("rst_dc", 32'(byte_dc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);

    // clear accepted on the first edge after reset release
    reset = 1'b0; clear = 1'b1;
    clear_wait(n, vs);
    chk("clear_cycles", 32'(n), 32'd1024);
    chk("clear_no_valid", 32'(vs), 32'd0);

    run_frame(1'b0, 0, 1'b0);
    check_frame("blank");

    foreach (pv[i]) wr_pix(pv[i].x, pv[i].y, pv[i].v);
    run_frame(1'b0, 0, 1'b0);
    check_frame("pixels");
    foreach (pv[i]) chk("pix_byte", 32'(cap_data[6 + pv[i].addr]), 32'(pv[i].exp));

    run_frame(1'b1, 0, 1'b0);
    check_frame("stall");

    run_frame(1'b0, 0, 1'b1);
    check_frame("poke");
    vlate = 0;
    repeat (10) begin
      @(negedge clk);
      if (byte_valid || busy) vlate++;
    end
    chk("no_second_frame", 32'(vlate), 32'd0);

    clear = 1'b1; frame_start = 1'b1;
    clear_wait(n, vs);
    chk("clr_fs_cycles", 32'(n), 32'd1024);
    chk("clr_fs_no_valid", 32'(vs), 32'd0);
    @(negedge clk);
    chk("clr_fs_idle_valid", 32'(byte_valid), 32'd0);
    chk("clr_fs_idle_busy", 32'(busy), 32'd0);
    wr_pix(7'd7, 6'd8, 1'b1);
    run_frame(1'b0, 0, 1'b0);
    check_frame("after_clr");
    chk("pix_7_8", 32'(cap_data[6 + 135]), 32'h01);

    run_frame(1'b1, 300, 1'b0);
    chk("abort_in_stream", 32'(byte_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(byte_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(byte_data), 32'd0);
    chk("midrst_dc", 32'(byte_dc), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(1'b0, 0, 1'b0);
    chk("restart_count", 32'(cap_n), 32'd1030);
    chk("restart_first", 32'(cap_data[0]), 32'h21);
    chk("restart_first_dc", 32'(cap_dc[0]), 32'd0);
    chk("restart_done", 32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_frame_streamer.md
OLED_FRAME_STREAMER -- requirements
Module: oled_frame_streamer

Interface
REQ-001 Parameter DISPLAY_WIDTH, default 128, pixel columns.
REQ-002 Parameter DISPLAY_HEIGHT, default 64, pixel rows; SHALL be a multiple of 8; PAGES = DISPLAY_HEIGHT/8.
REQ-003 Port clk  in  1  sole clock; all logic on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port pix_we  in  1  pixel write strobe.
REQ-006 Port pix_x  in  7  pixel column, 0..DISPLAY_WIDTH-1.
REQ-007 Port pix_y  in  6  pixel row, 0..DISPLAY_HEIGHT-1.
REQ-008 Port pix_val  in  1  pixel value, 1 = lit.
REQ-009 Port clear  in  1  one-cycle request to zero the framebuffer.
REQ-010 Port frame_start  in  1  one-cycle request to stream one full frame.
REQ-011 Port byte_data  out  8  byte offered to the downstream SPI/OLED driver.
REQ-012 Port byte_dc  out  1  0 = command byte, 1 = pixel data byte.
REQ-013 Port byte_valid  out  1  byte_data/byte_dc are valid.
REQ-014 Port byte_ready  in  1  downstream accepts the byte this cycle.
REQ-015 Port busy  out  1  high in any state other than IDLE.
REQ-016 Port frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-017 Framebuffer SHALL hold DISPLAY_WIDTH*PAGES bytes; pixel (x,y) SHALL map to bit y[2:0] of the byte at address y[5:3]*DISPLAY_WIDTH + x.
REQ-018 States SHALL be IDLE, CLEAR, HEADER, STREAM, DONE.
REQ-019 pix_we with in-range coordinates SHALL update the single addressed bit by the next edge, in IDLE, HEADER, STREAM or DONE; other bits of the byte unchanged.
REQ-020 pix_we with out-of-range x or y SHALL be ignored; pix_we in CLEAR SHALL be ignored.
REQ-021 IDLE + clear -> CLEAR; CLEAR SHALL zero one byte per cycle, address 0 upward, and return to IDLE after the last byte (DISPLAY_WIDTH*PAGES cycles).
REQ-022 IDLE + frame_start (clear low) -> HEADER; clear and frame_start asserted together in IDLE SHALL select CLEAR and drop frame_start.
REQ-023 clear or frame_start outside IDLE SHALL be ignored (not queued).
REQ-024 HEADER SHALL offer six bytes with byte_dc=0, in order: 0x21, 0x00, DISPLAY_WIDTH-1, 0x22, 0x00, PAGES-1.
REQ-025 STREAM SHALL offer all framebuffer bytes with byte_dc=1 in ascending address order (page 0 col 0..W-1, then page 1, ...).
REQ-026 A transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1.
REQ-027 While byte_valid=1 and byte_ready=0, byte_data and byte_dc SHALL hold stable and byte_valid SHALL stay high.
REQ-028 byte_valid SHALL rise within 2 cycles of accepted frame_start and within 2 cycles after each non-final transfer; back-to-back transfers (one per cycle) SHALL be permitted but not required.
REQ-029 Each data byte SHALL reflect all pixel writes completed before the cycle its framebuffer read is issued; a write to the same byte in that cycle MAY be excluded.
REQ-030 After the final data transfer, state SHALL be DONE for one cycle with frame_done=1, then IDLE.
REQ-031 byte_valid SHALL be 0 in IDLE, CLEAR and DONE; byte_data SHALL be 0 whenever byte_valid=0.
REQ-032 Byte address counter SHALL be wide enough for DISPLAY_WIDTH*PAGES-1 and SHALL not wrap within a frame.

Reset
REQ-033 reset high SHALL immediately force state IDLE, byte_valid=0, byte_data=0, byte_dc=0, busy=0, frame_done=0, counters 0, abandoning any clear or frame in progress.
REQ-034 Framebuffer contents SHALL be undefined after reset; reset SHALL not clear it.
REQ-035 First edge after reset deassertion SHALL accept clear or frame_start normally.

Verification
REQ-036 clear, wait for busy=0, frame_start, byte_ready=1 -> 6 header bytes 21,00,7F,22,00,07 (dc=0), then 1024 bytes 0x00 (dc=1), frame_done one pulse, busy low.
REQ-037 After clear, write pixels (0,0),(5,9),(127,63) = 1, stream -> byte 0 = 0x01, byte 133 = 0x02, byte 1023 = 0x80, all others 0x00.
REQ-038 Random byte_ready toggling during stream -> data held stable while stalled, no byte lost or duplicated, order per REQ-025.
REQ-039 clear and frame_start in same IDLE cycle -> CLEAR only, no bytes offered; frame_start during STREAM -> ignored, exactly one frame output.
REQ-040 reset asserted mid-STREAM after 300 data transfers -> byte_valid=0 same cycle, busy=0; subsequent frame_start restarts from header byte 0x21.
